viterbi_decoder: RTL and testbench
==================================

VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 Parameter: TB_DEPTH, default 36, survivor length in decoded bits (legal range 12..64).
REQ-002 Parameter: PM_W, default 8, path-metric width in bits.
REQ-003 Port: Clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: en  input  1  symbol strobe; data_in is consumed on every rising Clk edge where en=1.
REQ-006 Port: data_in  input  2  coded symbol pair; [0]=A (g0=133 octal), [1]=B (g1=171 octal).
REQ-007 Port: erase  input  2  per-bit erasure flags for punctured positions; present only under VITERBI_ERASURE_EN.
REQ-008 Port: data_out  output  1  decoded bit.
REQ-009 Port: valid_out  output  1  one-cycle qualifier for data_out.

Function
REQ-010 The block SHALL decode the 802.11a K=7, rate-1/2 code with hard decisions, 64 states.
REQ-011 State definition: s[5] = newest past input bit and s[0] = oldest; with input u, next state = {u, s[5:1]}.
REQ-012 Expected outputs per branch: A = u^s[4]^s[3]^s[1]^s[0]; B = u^s[5]^s[4]^s[3]^s[0].
REQ-013 Branch metric SHALL be the Hamming distance, 0..2, between data_in and the expected {B,A}.
REQ-014 ACS: the predecessors of state t are {t[4:0],0} and {t[4:0],1}, with u = t[5].
REQ-015 ACS SHALL select the smaller sum; on a tie it SHALL select the predecessor with LSB 0.
REQ-016 All state updates (metrics, survivors, fill counter) SHALL occur only on edges with en=1; with en=0, all state holds.
REQ-017 Survivor memory SHALL use register exchange: surv[t] <= {surv[pred][TB_DEPTH-2:0], u}, so index TB_DEPTH-1 holds the oldest bit.
REQ-018 Normalization: when the minimum of the new metrics is >= 2^(PM_W-2), 2^(PM_W-2) SHALL be subtracted from all 64 metrics on the same edge.
REQ-019 No path metric SHALL ever wrap.
REQ-020 best = lowest-index state of minimum metric, evaluated over the metrics registered before the current edge.
REQ-021 On each en=1 edge with fill counter = TB_DEPTH, the block SHALL register data_out = surv[best][TB_DEPTH-1] and valid_out = 1.
REQ-022 Fill counter: counts en=1 edges and saturates at TB_DEPTH.
REQ-023 Before saturation, valid_out SHALL be 0 and data_out SHALL hold.
REQ-024 Latency: data bit n appears with valid_out on the en edge that consumes symbol n+TB_DEPTH.
REQ-025 Outputs are registered; no combinational path from inputs to outputs.
REQ-026 valid_out SHALL be 0 on any edge with en=0; data_out holds its last value.

Reset
REQ-027 While reset=0, regardless of Clk: state-0 metric = 0, all other metrics = 32, survivors = 0, fill counter = 0, data_out = 0, valid_out = 0.
REQ-028 Reset asserted mid-stream SHALL discard all history.
REQ-029 After release, decoding SHALL restart as from power-up; the first valid_out occurs TB_DEPTH+1 en-edges after release.

Configuration
REQ-030 Macro VITERBI_ERASURE_EN, when defined: the erase port exists, and an erased bit contributes 0 to the branch metric.
REQ-031 With VITERBI_ERASURE_EN defined, erase=2'b11 yields branch metric 0 on all branches.
REQ-032 Macro VITERBI_ERASURE_EN, when undefined: the erase port is absent and both bits always count.
REQ-033 Bit-exact results SHALL be identical for both builds when erase=2'b00.

Verification
REQ-034 Reset, then en=1 with data_in=2'b00 for 100 cycles -> valid_out first high on en-edge 37; data_out=0 throughout.
REQ-035 Bits 1,0,1,1,0,0,1,0 followed by 60 zeros, encoded (first pair 2'b11) -> decoded sequence identical, delayed by 36 symbols.
REQ-036 Stream of REQ-035 with data_in[0] inverted on symbol 5 -> decoded output unchanged.
REQ-037 Stream of REQ-035 with en deasserted for 3 cycles at symbols 10, 20 and 30 -> identical output bits; valid_out=0 during the gaps.
REQ-038 reset pulsed low at symbol 40 of a random encoded stream -> outputs 0 immediately; correct decoding resumes with first valid_out after 37 en-edges.
REQ-039 (VITERBI_ERASURE_EN) Rate-3/4 depunctured stream of 200 random bits, with erase marking the punctured bits -> zero decoded bit errors.

Source files
------------

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=7 rate-1/2 (133,171) code, 64 states, register-exchange survivors.
// Latency: decoded bit n is registered on the en edge that consumes symbol n+TB_DEPTH; outputs registered.
// Backpressure: none; en strobes one symbol per edge and all state holds while en=0. Optional VITERBI_ERASURE_EN adds erase.
module viterbi_decoder #(
  parameter int TB_DEPTH = 36,
  parameter int PM_W     = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] data_in,
`ifdef VITERBI_ERASURE_EN
  input  logic [1:0] erase,
`endif
  output logic       data_out,
  output logic       valid_out
);

  localparam int NS = 64;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] NORM = PM_W'(1) << (PM_W - 2);

  logic [PM_W-1:0]     pm       [NS];
  logic [PM_W-1:0]     pm_new   [NS];
  logic [TB_DEPTH-1:0] surv     [NS];
  logic [TB_DEPTH-1:0] surv_new [NS];
  logic [NS-1:0]       dec;
  logic [CW-1:0]       fill;
  logic [1:0]          msk;
  logic [PM_W-1:0]     new_min;
  logic [PM_W-1:0]     best_pm;
  logic [5:0]          best;
  logic                norm;

  // Hamming distance between the received pair and the branch's expected {B,A}; masked bits count 0.
  function automatic logic [1:0] branch_metric(input logic [5:0] s, input logic u,
                                               input logic [1:0] sym, input logic [1:0] m);
    logic       a;
    logic       b;
    logic [1:0] diff;
    a    = u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
    b    = u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
    diff = (sym ^ {b, a}) & m;
    return {1'b0, diff[0]} + {1'b0, diff[1]};
  endfunction

`ifdef VITERBI_ERASURE_EN
  assign msk = ~erase;
`else
  assign msk = 2'b11;
`endif

  // Add-compare-select per destination state; ties go to the even predecessor.
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [5:0] ST = 6'(g);
    localparam logic [5:0] P0 = {ST[4:0], 1'b0};
    localparam logic [5:0] P1 = {ST[4:0], 1'b1};
    logic [PM_W:0] sum0;
    logic [PM_W:0] sum1;
    logic [PM_W:0] pick;
    assign sum0 = {1'b0, pm[P0]} + {{(PM_W-1){1'b0}}, branch_metric(P0, ST[5], data_in, msk)};
    assign sum1 = {1'b0, pm[P1]} + {{(PM_W-1){1'b0}}, branch_metric(P1, ST[5], data_in, msk)};
    assign dec[g]  = (sum1 < sum0);
    assign pick    = dec[g] ? sum1 : sum0;
    // Saturate rather than wrap if a metric ever overflows before normalization catches it.
    assign pm_new[g]   = pick[PM_W] ? {PM_W{1'b1}} : pick[PM_W-1:0];
    assign surv_new[g] = dec[g] ? {surv[P1][TB_DEPTH-2:0], ST[5]}
                                : {surv[P0][TB_DEPTH-2:0], ST[5]};
  end

  // Minimum of the freshly computed metrics decides whether to renormalize this edge.
  always_comb begin
    new_min = pm_new[0];
    for (int i = 1; i < NS; i++) begin
      if (pm_new[i] < new_min) new_min = pm_new[i];
    end
  end

  assign norm = (new_min >= NORM);

  // Best state: lowest index holding the minimum of the currently registered metrics.
  always_comb begin
    best    = '0;
    best_pm = pm[0];
    for (int i = 1; i < NS; i++) begin
      if (pm[i] < best_pm) begin
        best_pm = pm[i];
        best    = 6'(i);
      end
    end
  end

  // Metric/survivor/fill update on en edges; registered output once the survivors are full.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_W'(32);
        surv[i] <= '0;
      end
      fill      <= '0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (en) begin
        for (int i = 0; i < NS; i++) begin
          pm[i]   <= norm ? (pm_new[i] - NORM) : pm_new[i];
          surv[i] <= surv_new[i];
        end
        if (fill == CW'(TB_DEPTH)) begin
          data_out  <= surv[best][TB_DEPTH-1];
          valid_out <= 1'b1;
        end else begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: table of encoded streams plus a mid-stream reset sequence.
// Expected decoded bits are the message bits fed to a reference encoder; first valid expected on en-edge 37.
// Build with VITERBI_ERASURE_EN to add the punctured rate-3/4 vector.
module tb_viterbi_decoder;

  localparam int TB_DEPTH = 36;

  logic       Clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] data_in;
  logic [1:0] erase;
  logic       data_out;
  logic       valid_out;

  int total = 0;
  int bad   = 0;
  logic msg [0:299];

  typedef struct {
    string      name;
    logic [7:0] head;
    bit         rnd;
    int         nsym;
    int         flip;
    bit         gaps;
    bit         punct;
    int         first_valid;
  } vec_t;

  viterbi_decoder dut (
    .Clk(Clk),
    .reset(reset),
    .en(en),
    .data_in(data_in),
`ifdef VITERBI_ERASURE_EN
    .erase(erase),
`endif
    .data_out(data_out),
    .valid_out(valid_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] head, input bit rnd,
                              input int nsym, input int flip, input bit gaps, input bit punct);
    vec_t v;
    v.name = name; v.head = head; v.rnd = rnd; v.nsym = nsym;
    v.flip = flip; v.gaps = gaps; v.punct = punct; v.first_valid = TB_DEPTH + 1;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; data_in = 2'b00; erase = 2'b00;
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
  endtask

  // Encodes msg[0..nsym-1] from state 0 and checks every en edge against the message.
  task automatic feed(input string nm, input int nsym, input int flip, input bit gaps,
                      input bit punct, input int exp_first);
    logic [5:0] s;
    int         edges;
    int         first;
    logic       last;
    logic       u, a, b;
    logic [1:0] sym, er;
    s = '0; edges = 0; first = -1; last = 1'b0;
    for (int i = 0; i < nsym; i++) begin
      if (gaps && (i == 10 || i == 20 || i == 30)) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge Clk);
          en = 1'b0; data_in = 2'($urandom); erase = 2'b00;
          @(posedge Clk); #1;
          check({nm, "_gap_valid"}, valid_out, 0);
          check({nm, "_gap_hold"}, data_out, last);
        end
      end
      u = msg[i];
      a = u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
      b = u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
      sym = {b, a};
      er  = 2'b00;
      if (punct && (i % 3 == 1)) begin
        er = 2'b10; sym[1] = ~sym[1];
      end else if (punct && (i % 3 == 2)) begin
        er = 2'b01; sym[0] = ~sym[0];
      end
      if (i == flip) sym[0] = ~sym[0];
      s = {u, s[5:1]};
      @(negedge Clk);
      en = 1'b1; data_in = sym; erase = er;
      @(posedge Clk); #1;
      edges++;
      if (valid_out && first < 0) first = edges;
      if (edges > TB_DEPTH) begin
        check({nm, "_valid"}, valid_out, 1);
        check({nm, "_data"}, data_out, msg[edges-1-TB_DEPTH]);
        last = msg[edges-1-TB_DEPTH];
      end else begin
        check({nm, "_fill_valid"}, valid_out, 0);
        check({nm, "_fill_hold"}, data_out, last);
      end
    end
    @(negedge Clk);
    en = 1'b0; erase = 2'b00;
    check({nm, "_first_valid_edge"}, first, exp_first);
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk("zeros",   8'h00, 1'b0, 100, -1, 1'b0, 1'b0));
    vecs.push_back(mk("pattern", 8'hB2, 1'b0,  68, -1, 1'b0, 1'b0));
    vecs.push_back(mk("flip5",   8'hB2, 1'b0,  68,  5, 1'b0, 1'b0));
    vecs.push_back(mk("gaps",    8'hB2, 1'b0,  68, -1, 1'b1, 1'b0));
    vecs.push_back(mk("random",  8'h00, 1'b1,  90, -1, 1'b0, 1'b0));
`ifdef VITERBI_ERASURE_EN
    vecs.push_back(mk("punct34", 8'h00, 1'b1, 200 + TB_DEPTH, -1, 1'b0, 1'b1));
`endif

    reset = 1'b0; en = 1'b0; data_in = 2'b00; erase = 2'b00;

    for (int k = 0; k < vecs.size(); k++) begin
      for (int i = 0; i < vecs[k].nsym; i++) begin
        if (vecs[k].rnd) msg[i] = 1'($urandom_range(0, 1));
        else             msg[i] = (i < 8) ? vecs[k].head[7-i] : 1'b0;
      end
      do_reset();
      feed(vecs[k].name, vecs[k].nsym, vecs[k].flip, vecs[k].gaps,
           vecs[k].punct, vecs[k].first_valid);
    end

    // Mid-stream reset: the last pre-reset output is forced to 1 so the async clear is visible.
    for (int i = 0; i < 40; i++) msg[i] = 1'($urandom_range(0, 1));
    msg[3] = 1'b1;
    do_reset();
    feed("pre_reset", 40, -1, 1'b0, 1'b0, TB_DEPTH + 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      en = 1'b1; data_in = 2'b11;
      @(posedge Clk); #1;
      check("rst_held_valid", valid_out, 0);
      check("rst_held_data", data_out, 0);
    end
    @(negedge Clk);
    en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 80; i++) msg[i] = 1'($urandom_range(0, 1));
    feed("post_reset", 80, -1, 1'b0, 1'b0, TB_DEPTH + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
